jk_bank_arbiter: RTL and testbench
==================================

// Module: jk_bank_arbiter
// PURPOSE
//  Owns a bank of NUM_FF JK flip-flops and shares write access among NUM_REQ requesters.
//  Each requester issues a {j,k} command to one flop address over a valid/ready handshake.
//  A round-robin arbiter accepts at most one command per clock.
//  Also reports the last grant and counts contention cycles; sits between control FSMs and the flag bank.
// PARAMETERS
//  NUM_REQ  4   number of requesters (>=2)
//  NUM_FF   8   flops in the bank (>=2)
//  AW       $clog2(NUM_FF)  address width
//  IDW      $clog2(NUM_REQ) requester-id width
//  CNT_W    16  contention counter width
// PORTS
//  clk          in   1            rising-edge clock
//  reset        in   1            asynchronous, active-low reset
//  clr_all      in   1            synchronous clear of whole bank
//  req_valid    in   NUM_REQ      per-requester command valid
//  req_jk       in   2*NUM_REQ    per-requester {j,k}; slice i = [2i+1:2i]
//  req_addr     in   AW*NUM_REQ   per-requester flop index; slice i = [AW*i+:AW]
//  req_ready    out  NUM_REQ      one-hot (or zero) accept strobe
//  q            out  NUM_FF       flop bank state
//  grant_valid  out  1            registered: a command was accepted last cycle
//  grant_id     out  IDW          registered: requester accepted last cycle
//  contend_cnt  out  CNT_W        saturating count of contention cycles
// BEHAVIOUR
//  Reset (reset=0, async): q=0, rr_ptr=0, grant_valid=0, grant_id=0, contend_cnt=0.
//    req_ready forced 0 while reset is low.
//  Arbitration (combinational):
//    Winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
//    req_ready[winner]=1, all others 0. No valid requester -> req_ready=0.
//    req_ready may depend on req_valid; requesters must not gate valid on ready.
//  Handshake: accept = valid&ready.
//    A requester holds valid, jk and addr stable until accepted; valid never drops before accept.
//  Command apply, at the accept edge, to q[addr]:
//    00 hold; 01 q=0; 10 q=1; 11 q=~q. New q is visible the cycle after accept (latency 1).
//    addr >= NUM_FF: command is accepted and discarded; q unchanged; grant still reported.
//  Pointer: on accept from i, rr_ptr <= (i+1) mod NUM_REQ; with no accept, rr_ptr holds.
//    Wrap: accept from NUM_REQ-1 -> rr_ptr=0.
//  grant_valid/grant_id: registered copy of this cycle's accept and winner.
//    grant_id holds its old value when grant_valid=0.
//  contend_cnt: +1 on every cycle where popcount(req_valid)>=2. Saturates at all-ones; no wrap.
//  clr_all=1: q<=0 at that edge; req_ready=0 that cycle (no accept, rr_ptr holds, grant_valid<=0).
//    contend_cnt still counts. clr_all has priority over any command.
//  Reset asserted mid-handshake: command is lost, state returns to reset values immediately.
//    Requesters re-present after reset deasserts.
// STRUCTURE
//  Package jk_bank_pkg:
//    enum jk_cmd_e {JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10, JK_TOG=2'b11}.
//    Function jk_next(q, cmd) returning the next state.
//  Sub-module jk_cell: one JK flop with async active-low reset, enable and sync clear.
//    Instantiated NUM_FF times via generate; enable = accept & (addr==n).
//  Arbiter, pointer, grant registers and counter live in jk_bank_arbiter.
// TESTING
//  1 Reset: hold reset=0 with random inputs ->
//    q=0, req_ready=0, grant_valid=0, contend_cnt=0; checked asynchronously, mid-cycle.
//  2 Single requester: req1 issues SET addr3, TOG addr3, RST addr5, HOLD addr0 ->
//    Each command is accepted in one cycle. q[3]: 1, then 0; q[5]=0; q unchanged on HOLD.
//    grant_id=1 each following cycle.
//  3 Round-robin: all 4 requesters valid continuously with TOG on distinct addrs ->
//    Grants 0,1,2,3,0,... Each flop toggles once per 4 cycles; contend_cnt +1 per cycle.
//  4 Wrap/skip: rr_ptr=3, only req0 and req2 valid ->
//    Grant order 0,2,0,2 (req3 and req1 skipped).
//  5 clr_all + out-of-range: q=8'hFF.
//    Assert clr_all while req0 valid -> q=0 next cycle, req_ready=0, req0 accepted next cycle.
//    req0 SET addr=NUM_FF (if representable) -> accepted, q unchanged.
//  6 Saturation and reset mid-op: CNT_W=4, 20 contention cycles -> contend_cnt stays 4'hF.
//    Pulse reset low between valid and accept -> no q change, counter=0.

Source files
------------

// File: rtl/jk_bank_pkg.sv
// Shared command encoding and next-state rule for the JK flag bank.
package jk_bank_pkg;

   typedef enum logic [1:0] {
      JK_HOLD = 2'b00,
      JK_RST  = 2'b01,
      JK_SET  = 2'b10,
      JK_TOG  = 2'b11
   } jk_cmd_e;

   function automatic logic jk_next(input logic q, input jk_cmd_e cmd);
      logic nxt;
      case (cmd)
         JK_RST:  nxt = 1'b0;
         JK_SET:  nxt = 1'b1;
         JK_TOG:  nxt = ~q;
         default: nxt = q;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK flag: clear beats the enabled command; holds otherwise.
module jk_cell
   import jk_bank_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       clr,
   input  logic [1:0] cmd,
   output logic       q
);

   logic q_q;
   logic q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = 1'b0;
      end else if (en) begin
         q_d = jk_next(q_q, jk_cmd_e'(cmd));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin shared write port onto a bank of JK flags, with grant
// reporting and a saturating count of cycles where requesters collide.
module jk_bank_arbiter
   import jk_bank_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int NUM_FF  = 8,
   parameter int CNT_W   = 16,
   localparam int AW     = $clog2(NUM_FF),
   localparam int IDW    = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clr_all,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [2*NUM_REQ-1:0]   req_jk,
   input  logic [AW*NUM_REQ-1:0]  req_addr,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [NUM_FF-1:0]      q,
   output logic                   grant_valid,
   output logic [IDW-1:0]         grant_id,
   output logic [CNT_W-1:0]       contend_cnt
);

   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic             grant_valid_q, grant_valid_d;
   logic [IDW-1:0]   grant_id_q, grant_id_d;
   logic [CNT_W-1:0] contend_cnt_q, contend_cnt_d;

   logic             win_found;
   logic [IDW-1:0]   win_id;
   logic [IDW:0]     arb_sum;
   logic [IDW-1:0]   arb_idx;
   logic             accept;
   logic [1:0]       sel_jk;
   logic [AW-1:0]    sel_addr;
   logic             contend;

   // Search starts at rr_ptr and wraps modulo NUM_REQ (need not be a power of two).
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      arb_sum   = '0;
      arb_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         arb_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
         if (arb_sum >= (IDW+1)'(NUM_REQ)) begin
            arb_sum = arb_sum - (IDW+1)'(NUM_REQ);
         end
         arb_idx = arb_sum[IDW-1:0];
         if (!win_found && req_valid[arb_idx]) begin
            win_found = 1'b1;
            win_id    = arb_idx;
         end
      end
   end

   // Ready is gated by reset directly so it drops the moment reset asserts.
   assign accept = win_found & reset & ~clr_all;

   always_comb begin
      req_ready = '0;
      sel_jk    = '0;
      sel_addr  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_id == IDW'(i)) begin
            req_ready[i] = accept;
            sel_jk       = req_jk[2*i +: 2];
            sel_addr     = req_addr[AW*i +: AW];
         end
      end
   end

   assign contend = ($countones(req_valid) >= 2);

   always_comb begin
      rr_ptr_d      = rr_ptr_q;
      grant_valid_d = accept;
      grant_id_d    = grant_id_q;
      contend_cnt_d = contend_cnt_q;
      if (accept) begin
         grant_id_d = win_id;
         rr_ptr_d   = (win_id == IDW'(NUM_REQ-1)) ? '0 : win_id + 1'b1;
      end
      if (contend && (contend_cnt_q != '1)) begin
         contend_cnt_d = contend_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr_q      <= '0;
         grant_valid_q <= 1'b0;
         grant_id_q    <= '0;
         contend_cnt_q <= '0;
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         grant_valid_q <= grant_valid_d;
         grant_id_q    <= grant_id_d;
         contend_cnt_q <= contend_cnt_d;
      end
   end

   // Addresses past the bank match no cell, so such commands are dropped.
   for (genvar n = 0; n < NUM_FF; n++) begin : g_cell
      jk_cell u_cell (
         .clk   (clk),
         .rst_n (reset),
         .en    (accept && (sel_addr == AW'(n))),
         .clr   (clr_all),
         .cmd   (sel_jk),
         .q     (q[n])
      );
   end

   assign grant_valid = grant_valid_q;
   assign grant_id    = grant_id_q;
   assign contend_cnt = contend_cnt_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench: a default 8-flop instance and a 6-flop / 4-bit-counter
// instance share stimulus, so out-of-range addresses and saturation are reachable.
module tb_jk_bank_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        clr_all = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [7:0]  req_jk = '0;
   logic [11:0] req_addr = '0;

   logic [3:0]  ready_a, ready_b;
   logic [7:0]  q_a;
   logic [5:0]  q_b;
   logic        gv_a, gv_b;
   logic [1:0]  gid_a, gid_b;
   logic [15:0] cnt_a;
   logic [3:0]  cnt_b;

   jk_bank_arbiter #(.NUM_REQ(4), .NUM_FF(8), .CNT_W(16)) u_dut (
      .clk(clk), .reset(reset), .clr_all(clr_all), .req_valid(req_valid),
      .req_jk(req_jk), .req_addr(req_addr), .req_ready(ready_a), .q(q_a),
      .grant_valid(gv_a), .grant_id(gid_a), .contend_cnt(cnt_a)
   );

   jk_bank_arbiter #(.NUM_REQ(4), .NUM_FF(6), .CNT_W(4)) u_dut_s (
      .clk(clk), .reset(reset), .clr_all(clr_all), .req_valid(req_valid),
      .req_jk(req_jk), .req_addr(req_addr), .req_ready(ready_b), .q(q_b),
      .grant_valid(gv_b), .grant_id(gid_b), .contend_cnt(cnt_b)
   );

   always #5 clk = ~clk;

   int n_tot = 0;
   int n_pass = 0;
   bit run = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: plain integers and arrays, updated from the spec rules.
   bit   mq0 [8];
   bit   mq1 [6];
   int   mrr, mid, mcnt0, mcnt1;
   bit   mgv;
   int   exp_q[$];

   function automatic int model_winner();
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (mrr + k) % 4;
         if (req_valid[i]) return i;
      end
      return -1;
   endfunction

   function automatic bit apply(input bit cur, input int cmd);
      case (cmd)
         1: return 1'b0;
         2: return 1'b1;
         3: return !cur;
         default: return cur;
      endcase
   endfunction

   function automatic longint pack_q0();
      longint v = 0;
      for (int i = 0; i < 8; i++) if (mq0[i]) v |= (64'd1 << i);
      return v;
   endfunction

   function automatic longint pack_q1();
      longint v = 0;
      for (int i = 0; i < 6; i++) if (mq1[i]) v |= (64'd1 << i);
      return v;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) mq0[i] = 0;
         for (int i = 0; i < 6; i++) mq1[i] = 0;
         mrr = 0; mid = 0; mgv = 0; mcnt0 = 0; mcnt1 = 0;
         exp_q.delete();
      end else begin
         int w, nv, a, c;
         w = model_winner();
         nv = 0;
         for (int i = 0; i < 4; i++) nv += req_valid[i];
         if (nv >= 2) begin
            if (mcnt0 < 65535) mcnt0++;
            if (mcnt1 < 15) mcnt1++;
         end
         mgv = 0;
         if (clr_all) begin
            for (int i = 0; i < 8; i++) mq0[i] = 0;
            for (int i = 0; i < 6; i++) mq1[i] = 0;
         end else if (w >= 0) begin
            a = int'(req_addr[3*w +: 3]);
            c = int'(req_jk[2*w +: 2]);
            if (a < 8) mq0[a] = apply(mq0[a], c);
            if (a < 6) mq1[a] = apply(mq1[a], c);
            mrr = (w + 1) % 4;
            mgv = 1;
            mid = w;
            exp_q.push_back(w);
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT reports a grant.
   always @(negedge clk) begin
      if (run && reset) begin
         chk("grant_valid", gv_a, mgv);
         chk("grant_valid_s", gv_b, mgv);
         if (gv_a) begin
            if (exp_q.size() == 0) chk("unexpected_grant", 1, 0);
            else begin
               int e;
               e = exp_q.pop_front();
               chk("grant_id", gid_a, e);
               chk("grant_id_s", gid_b, e);
            end
         end else begin
            chk("grant_id_hold", gid_a, mid);
         end
         chk("q", q_a, pack_q0());
         chk("q_s", q_b, pack_q1());
         chk("contend_cnt", cnt_a, mcnt0);
         chk("contend_cnt_s", cnt_b, mcnt1);
      end
   end

   // Per-requester pending commands; a command stays put until accepted.
   bit       pv [4];
   bit [1:0] pjk [4];
   bit [2:0] pad [4];
   bit       pclr;

   task automatic step();
      int w;
      logic [3:0] er;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         req_valid[i]        = pv[i];
         req_jk[2*i +: 2]    = pjk[i];
         req_addr[3*i +: 3]  = pad[i];
      end
      clr_all = pclr;
      #1;
      w = model_winner();
      er = (reset && !pclr && w >= 0) ? (4'b1 << w) : 4'b0;
      chk("req_ready", ready_a, er);
      chk("req_ready_s", ready_b, er);
      @(posedge clk);
      #1;
      if (mgv) pv[mid] = 0;
   endtask

   task automatic set_cmd(input int r, input int cmd, input int a);
      pv[r] = 1; pjk[r] = 2'(cmd); pad[r] = 3'(a);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin pv[i] = 0; pjk[i] = 0; pad[i] = 0; end
      pclr = 0;

      // Reset held with random inputs; outputs checked mid-cycle.
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         req_valid = 4'($urandom); req_jk = 8'($urandom);
         req_addr = 12'($urandom); clr_all = 1'($urandom);
         #3;
         chk("rst_q", q_a, 0);
         chk("rst_ready", ready_a, 0);
         chk("rst_gv", gv_a, 0);
         chk("rst_cnt", cnt_a, 0);
      end
      @(negedge clk);
      req_valid = '0; clr_all = 0;
      reset = 1;
      run = 1;

      // Single requester 1.
      set_cmd(1, 2, 3); step();
      set_cmd(1, 3, 3); step();
      set_cmd(1, 1, 5); step();
      set_cmd(1, 0, 0); step();
      step();

      // All four toggling distinct addresses.
      for (int c = 0; c < 12; c++) begin
         for (int r = 0; r < 4; r++) if (!pv[r]) set_cmd(r, 3, r + 4);
         step();
      end
      for (int r = 0; r < 4; r++) pv[r] = 0;
      step();

      // Move pointer to 3, then only 0 and 2 compete.
      set_cmd(2, 0, 1); step();
      for (int c = 0; c < 4; c++) begin
         if (!pv[0]) set_cmd(0, 3, 1);
         if (!pv[2]) set_cmd(2, 3, 2);
         step();
      end
      pv[0] = 0; pv[2] = 0;

      // Fill bank, clear with a pending request, then out-of-range writes.
      for (int a = 0; a < 8; a++) begin set_cmd(0, 2, a); step(); end
      set_cmd(0, 2, 6);
      pclr = 1; step();
      pclr = 0; step();
      set_cmd(0, 2, 7); step();
      step();

      // Saturation of the 4-bit counter.
      for (int c = 0; c < 20; c++) begin
         for (int r = 0; r < 4; r++) set_cmd(r, 0, r);
         step();
      end
      for (int r = 0; r < 4; r++) pv[r] = 0;
      step();
      chk("cnt_saturated_s", cnt_b, 15);

      // Reset pulse between valid and accept.
      @(negedge clk);
      req_valid = 4'b0001; req_jk[1:0] = 2'b11; req_addr[2:0] = 3'd2;
      #2 reset = 0;
      #1;
      chk("midrst_q", q_a, 0);
      chk("midrst_cnt", cnt_a, 0);
      chk("midrst_ready", ready_a, 0);
      req_valid = '0;
      #1 reset = 1;
      step();
      step();

      // Random traffic honouring the hold-until-accepted rule.
      for (int c = 0; c < 400; c++) begin
         for (int r = 0; r < 4; r++)
            if (!pv[r] && $urandom_range(0, 1) == 1)
               set_cmd(r, $urandom_range(0, 3), $urandom_range(0, 7));
         pclr = ($urandom_range(0, 19) == 0);
         step();
      end
      pclr = 0;
      for (int r = 0; r < 4; r++) pv[r] = 0;
      step();
      step();
      chk("scoreboard_drained", exp_q.size(), 0);

      run = 0;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
